// File: rtl/sniffer_pkg.sv
// Shared types and default sizing for the packet-sniffer match path.
package sniffer_pkg;

   localparam int NUM_SRC_DEF    = 4;
   localparam int FIFO_DEPTH_DEF = 8;
   localparam int PKT_W_DEF      = 16;

   typedef enum logic [1:0] {
      SRC_MAC_DST = 2'd0,
      SRC_MAC_SRC = 2'd1,
      SRC_IP      = 2'd2,
      SRC_URL     = 2'd3
   } src_id_e;

   typedef struct packed {
      src_id_e                src;
      logic [PKT_W_DEF-1:0]   pkt;
   } match_event_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO for match events; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module event_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr, rptr;
   logic             do_pop, do_push;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/match_arbiter.sv
// Collects comparator match pulses, arbitrates round-robin among pending
// sources and queues {source, packet number} events for the host.
module match_arbiter
   import sniffer_pkg::*;
#(
   parameter int NUM_SRC    = NUM_SRC_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int PKT_W      = PKT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC-1:0]         match,
   input  logic                       pkt_start,
   input  logic                       clr_ovf,
   output logic [NUM_SRC-1:0]         comp_clear,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic [$clog2(NUM_SRC)-1:0] ev_src,
   output logic [PKT_W-1:0]           ev_pkt,
   output logic [NUM_SRC-1:0]         pending,
   output logic                       overflow
);

   localparam int SRC_W = $clog2(NUM_SRC);
   localparam int EV_W  = SRC_W + PKT_W;

   logic [SRC_W-1:0]   rr_ptr, gnt_idx;
   logic [PKT_W-1:0]   pkt_cnt;
   logic [NUM_SRC-1:0] gnt_oh, lost;
   logic [EV_W-1:0]    head;
   logic               gnt_vld, fifo_full, fifo_empty, pop;
   int                 idx;

   assign pop = !fifo_empty && ev_ready;

   // Scan from the farthest offset down so the source nearest rr_ptr wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      if (!fifo_full || pop) begin
         for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (pending[idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = SRC_W'(idx);
            end
         end
      end
   end

   assign gnt_oh = {{(NUM_SRC-1){1'b0}}, gnt_vld} << gnt_idx;
   assign lost   = match & pending & ~gnt_oh;

   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= '0;
         rr_ptr     <= '0;
         pkt_cnt    <= '0;
         comp_clear <= '0;
         overflow   <= 1'b0;
      end else begin
         // A new match on the granted source re-arms it.
         pending    <= (pending & ~gnt_oh) | match;
         comp_clear <= gnt_oh;
         overflow   <= (|lost) | (overflow & ~clr_ovf);
         if (pkt_start) pkt_cnt <= pkt_cnt + 1'b1;
         if (gnt_vld)
            rr_ptr <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   event_fifo #(.WIDTH(EV_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (gnt_vld),
      .din   ({gnt_idx, pkt_cnt}),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ev_valid = !fifo_empty;
   assign ev_src   = ev_valid ? head[EV_W-1:PKT_W] : '0;
   assign ev_pkt   = ev_valid ? head[PKT_W-1:0]    : '0;

endmodule

// File: tb/tb_match_arbiter.sv
// Directed bench for match_arbiter with a queue-based reference model
// checked every cycle plus literal expectations for key scenarios.
module tb_match_arbiter;

   localparam int N     = 4;
   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] match = '0;
   logic         pkt_start = 1'b0;
   logic         clr_ovf = 1'b0;
   logic         ev_ready = 1'b0;
   logic [N-1:0] comp_clear;
   logic         ev_valid;
   logic [1:0]   ev_src;
   logic [15:0]  ev_pkt;
   logic [N-1:0] pending;
   logic         overflow;

   match_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(DEPTH), .PKT_W(16)) dut (
      .clk(clk), .rst(rst), .match(match), .pkt_start(pkt_start),
      .clr_ovf(clr_ovf), .comp_clear(comp_clear), .ev_valid(ev_valid),
      .ev_ready(ev_ready), .ev_src(ev_src), .ev_pkt(ev_pkt),
      .pending(pending), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending sources as bits, event FIFO as a queue.
   typedef struct { int src; int pkt; } ev_t;
   ev_t m_q[$];
   bit  m_pend[N];
   int  m_rr = 0, m_cnt = 0, m_gnt = -1;
   bit  m_ovf = 0;
   bit  chk_en = 0;

   always @(posedge clk) begin
      int g;
      bit popm, lostm;
      if (rst) begin
         m_q.delete();
         foreach (m_pend[i]) m_pend[i] = 0;
         m_rr = 0; m_cnt = 0; m_ovf = 0; m_gnt = -1;
      end else begin
         popm = (m_q.size() > 0) && ev_ready;
         g = -1;
         if (m_q.size() < DEPTH || popm)
            for (int k = 0; k < N; k++)
               if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
         lostm = 0;
         for (int i = 0; i < N; i++)
            if (match[i] && m_pend[i] && i != g) lostm = 1;
         if (popm) void'(m_q.pop_front());
         if (g >= 0) begin
            m_q.push_back('{src: g, pkt: m_cnt});
            m_rr = (g + 1) % N;
         end
         for (int i = 0; i < N; i++)
            m_pend[i] = (m_pend[i] && i != g) || match[i];
         if (pkt_start) m_cnt = (m_cnt + 1) % 65536;
         m_ovf = lostm || (m_ovf && !clr_ovf);
         m_gnt = g;
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] pe;
      if (chk_en) begin
         for (int i = 0; i < N; i++) pe[i] = m_pend[i];
         chk("ev_valid", 32'(ev_valid), 32'(m_q.size() > 0));
         if (m_q.size() > 0) begin
            chk("ev_src", 32'(ev_src), 32'(m_q[0].src));
            chk("ev_pkt", 32'(ev_pkt), 32'(m_q[0].pkt));
         end
         chk("pending", 32'(pending), 32'(pe));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("comp_clear", 32'(comp_clear), (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk_en = 1;
      chk("rst ev_valid", 32'(ev_valid), 0);
      chk("rst ev_src", 32'(ev_src), 0);
      chk("rst ev_pkt", 32'(ev_pkt), 0);
      chk("rst pending", 32'(pending), 0);
      chk("rst overflow", 32'(overflow), 0);
      chk("rst comp_clear", 32'(comp_clear), 0);

      // Single event, latency 2, packet number 3
      pkt_start = 1; repeat (3) step(); pkt_start = 0;
      match = 4'b0100; step(); match = 0;
      chk("single c1 pending", 32'(pending), 32'b0100);
      chk("single c1 ev_valid", 32'(ev_valid), 0);
      step();
      chk("single c2 ev_valid", 32'(ev_valid), 1);
      chk("single c2 ev_src", 32'(ev_src), 2);
      chk("single c2 ev_pkt", 32'(ev_pkt), 3);
      chk("single c2 comp_clear", 32'(comp_clear), 32'b0100);
      step();
      chk("single c3 comp_clear", 32'(comp_clear), 0);
      chk("single c3 hold src", 32'(ev_src), 2);
      ev_ready = 1; step(); ev_ready = 0;
      chk("single popped", 32'(ev_valid), 0);

      // Simultaneous matches drain 0,1,2,3 one per cycle
      do_reset();
      ev_ready = 1;
      match = 4'b1111; step(); match = 0;
      step();
      for (int s = 0; s < 4; s++) begin
         chk("simul valid", 32'(ev_valid), 1);
         chk("simul order", 32'(ev_src), 32'(s));
         step();
      end
      chk("simul drained", 32'(ev_valid), 0);

      // Fairness: after grant of 1, pointer at 2 -> order 0 then 1
      do_reset();
      ev_ready = 1;
      match = 4'b0010; step(); match = 0; step();
      chk("fair first src", 32'(ev_src), 1);
      match = 4'b0011; step(); match = 0; step();
      chk("fair second src", 32'(ev_src), 0);
      step();
      chk("fair third src", 32'(ev_src), 1);
      step();
      ev_ready = 0;

      // Backpressure: fill 8, hold pending, then lose a match
      do_reset();
      for (int i = 0; i < 8; i++) begin
         match = 4'b0001 << (i % 4); step();
      end
      match = 0; step(); step();
      chk("bp full valid", 32'(ev_valid), 1);
      chk("bp head src", 32'(ev_src), 0);
      chk("bp no ovf", 32'(overflow), 0);
      match = 4'b0001; step(); match = 0;
      chk("bp held pending", 32'(pending), 32'b0001);
      step();
      chk("bp still held", 32'(pending), 32'b0001);
      chk("bp still no ovf", 32'(overflow), 0);
      match = 4'b0001; step(); match = 0;
      chk("bp ovf set", 32'(overflow), 1);
      step(); step();
      chk("bp ovf sticky", 32'(overflow), 1);
      clr_ovf = 1; step(); clr_ovf = 0;
      chk("bp ovf cleared", 32'(overflow), 0);
      ev_ready = 1; step();
      chk("bp full push+pop src", 32'(ev_src), 1);
      chk("bp full push+pop pending", 32'(pending), 0);
      repeat (10) step();
      ev_ready = 0;
      chk("bp drained", 32'(ev_valid), 0);

      // Reset mid-run with 5 queued events and a pending flag
      match = 4'b1111; step(); match = 0;
      repeat (5) step();
      match = 4'b0001; step(); match = 0; step();
      match = 4'b0010; step(); match = 0;
      chk("mid pending before rst", 32'(pending), 32'b0010);
      rst = 1; match = 4'b1111; step(); rst = 0; match = 0;
      chk("mid ev_valid", 32'(ev_valid), 0);
      chk("mid pending", 32'(pending), 0);
      chk("mid overflow", 32'(overflow), 0);
      step();
      chk("mid match ignored", 32'(pending), 0);

      // Packet counter wrap, pkt_start coinciding with the grant
      pkt_start = 1; repeat (65535) step(); pkt_start = 0;
      match = 4'b1000; step(); match = 0;
      pkt_start = 1; step(); pkt_start = 0;
      chk("wrap src", 32'(ev_src), 3);
      chk("wrap pkt max", 32'(ev_pkt), 32'd65535);
      ev_ready = 1; step(); ev_ready = 0;
      match = 4'b1000; step(); match = 0; step();
      chk("wrap pkt zero", 32'(ev_pkt), 0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
